// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the H:M:S countdown timer: FSM encoding, field width,
// default field maxima and the load saturation helper.
package countdown_timer_pkg;

   localparam int FIELD_W = 6;

   localparam logic [FIELD_W-1:0] SEC_MAX_DEF = 6'd59;
   localparam logic [FIELD_W-1:0] MIN_MAX_DEF = 6'd59;
   localparam logic [FIELD_W-1:0] HRS_MAX_DEF = 6'd23;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_EXPIRED = 2'd2
   } state_t;

   function automatic logic [FIELD_W-1:0] sat_field(input logic [FIELD_W-1:0] val,
                                                    input logic [FIELD_W-1:0] max_val);
      return (val > max_val) ? max_val : val;
   endfunction

endpackage

// File: rtl/down_counter.sv
// One time field of the countdown: loadable, decrements when enabled and
// reloads count_max on the step that borrows from the next field up.
module down_counter
   import countdown_timer_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               en,
   input  logic               load,
   input  logic [FIELD_W-1:0] load_val,
   input  logic [FIELD_W-1:0] count_max,
   output logic               borrow,
   output logic [FIELD_W-1:0] count
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (en) begin
         count <= (count == '0) ? count_max : count - FIELD_W'(1);
      end
   end

   assign borrow = en && (count == '0);

endmodule

// File: rtl/countdown_timer.sv
// Loadable H:M:S countdown timer driven by a 1 Hz tick strobe; pulses done
// for one cycle when the count reaches 00:00:00.
//
//   state      | meaning
//   -----------+-----------------------------------------------------
//   ST_IDLE    | loaded or paused; counts held, waiting for start
//   ST_RUN     | decrementing one step per tick
//   ST_EXPIRED | reached zero; held at 0 until load or reset
module countdown_timer
   import countdown_timer_pkg::*;
#(
   parameter logic [FIELD_W-1:0] SEC_MAX = SEC_MAX_DEF,
   parameter logic [FIELD_W-1:0] MIN_MAX = MIN_MAX_DEF,
   parameter logic [FIELD_W-1:0] HRS_MAX = HRS_MAX_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               tick,
   input  logic               load,
   input  logic [FIELD_W-1:0] load_hrs,
   input  logic [FIELD_W-1:0] load_min,
   input  logic [FIELD_W-1:0] load_sec,
   input  logic               start,
   input  logic               stop,
   output logic [FIELD_W-1:0] count_hrs,
   output logic [FIELD_W-1:0] count_min,
   output logic [FIELD_W-1:0] count_sec,
   output logic               running,
   output logic               done
);

   state_t state, state_nxt;

   logic tick_en;
   logic expire_now;
   logic sec_borrow, min_borrow, hrs_borrow;
   logic is_zero, is_one;

   logic [FIELD_W-1:0] sat_hrs, sat_min, sat_sec;

   assign sat_hrs = sat_field(load_hrs, HRS_MAX);
   assign sat_min = sat_field(load_min, MIN_MAX);
   assign sat_sec = sat_field(load_sec, SEC_MAX);

   assign is_zero = (count_hrs == '0) && (count_min == '0) && (count_sec == '0);
   assign is_one  = (count_hrs == '0) && (count_min == '0) && (count_sec == FIELD_W'(1));

   down_counter u_sec (
      .clk       (clk),
      .reset     (reset),
      .en        (tick_en),
      .load      (load),
      .load_val  (sat_sec),
      .count_max (SEC_MAX),
      .borrow    (sec_borrow),
      .count     (count_sec)
   );

   down_counter u_min (
      .clk       (clk),
      .reset     (reset),
      .en        (sec_borrow),
      .load      (load),
      .load_val  (sat_min),
      .count_max (MIN_MAX),
      .borrow    (min_borrow),
      .count     (count_min)
   );

   // Hours never borrow: tick_en is gated off at zero, so the top field
   // cannot wrap below 00:00:00.
   down_counter u_hrs (
      .clk       (clk),
      .reset     (reset),
      .en        (min_borrow),
      .load      (load),
      .load_val  (sat_hrs),
      .count_max (HRS_MAX),
      .borrow    (hrs_borrow),
      .count     (count_hrs)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= ST_IDLE;
         running <= 1'b0;
         done    <= 1'b0;
      end else begin
         state   <= state_nxt;
         running <= (state_nxt == ST_RUN);
         done    <= expire_now;
      end
   end

   always_comb begin
      state_nxt  = state;
      tick_en    = 1'b0;
      expire_now = 1'b0;
      if (load) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (!stop && start && !is_zero) begin
                  state_nxt = ST_RUN;
               end
            end
            ST_RUN: begin
               if (stop) begin
                  state_nxt = ST_IDLE;
               end else if (tick && !is_zero) begin
                  tick_en = 1'b1;
                  if (is_one) begin
                     expire_now = 1'b1;
                     state_nxt  = ST_EXPIRED;
                  end
               end
            end
            ST_EXPIRED: begin
               state_nxt = ST_EXPIRED;
            end
            default: begin
               state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   logic unused_borrow;
   assign unused_borrow = hrs_borrow;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: directed scenarios plus a random
// run compared against a total-seconds reference model.
module tb_countdown_timer;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       tick = 1'b0;
   logic       load = 1'b0;
   logic [5:0] load_hrs = '0;
   logic [5:0] load_min = '0;
   logic [5:0] load_sec = '0;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic [5:0] count_hrs, count_min, count_sec;
   logic       running, done;

   int checks = 0;
   int errors = 0;

   // reference model: whole remaining time in seconds plus a mode
   int m_total = 0;
   int m_mode  = 0;   // 0 idle, 1 counting, 2 expired
   bit m_done  = 0;

   countdown_timer dut (
      .clk       (clk),
      .reset     (reset),
      .tick      (tick),
      .load      (load),
      .load_hrs  (load_hrs),
      .load_min  (load_min),
      .load_sec  (load_sec),
      .start     (start),
      .stop      (stop),
      .count_hrs (count_hrs),
      .count_min (count_min),
      .count_sec (count_sec),
      .running   (running),
      .done      (done)
   );

   always #5 clk = ~clk;

   function automatic int clip(input int v, input int mx);
      return (v > mx) ? mx : v;
   endfunction

   task automatic step(input bit ld, input int lh, input int lm, input int ls,
                       input bit st, input bit sp, input bit tk);
      @(negedge clk);
      load = ld; load_hrs = 6'(lh); load_min = 6'(lm); load_sec = 6'(ls);
      start = st; stop = sp; tick = tk;
      m_done = 0;
      if (ld) begin
         m_total = clip(lh, 23) * 3600 + clip(lm, 59) * 60 + clip(ls, 59);
         m_mode  = 0;
      end else if (m_mode == 0) begin
         if (!sp && st && m_total != 0) m_mode = 1;
      end else if (m_mode == 1) begin
         if (sp) m_mode = 0;
         else if (tk) begin
            m_total = m_total - 1;
            if (m_total == 0) begin
               m_mode = 2;
               m_done = 1;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      @(negedge clk);
      load = 0; start = 0; stop = 0; tick = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      load = 0; start = 0; stop = 0; tick = 0;
      m_total = 0; m_mode = 0; m_done = 0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      checks++;
      if ({count_hrs, count_min, count_sec, running, done} !== 20'd0) begin
         errors++;
         $display("FAIL reset_state got %0d:%0d:%0d run=%0b done=%0b exp 0:0:0 run=0 done=0",
                  count_hrs, count_min, count_sec, running, done);
      end
   endtask

   task automatic test_expiry();
      step(1, 0, 0, 3, 0, 0, 0);
      step(0, 0, 0, 0, 1, 0, 0);
      checks++;
      if (running !== 1'b1) begin
         errors++; $display("FAIL t1_start got run=%0b exp 1", running);
      end
      for (int i = 2; i >= 0; i--) begin
         step(0, 0, 0, 0, 0, 0, 1);
         checks++;
         if (count_sec !== 6'(i) || running !== (i != 0) || done !== (i == 0)) begin
            errors++;
            $display("FAIL t1_tick sec got %0d run=%0b done=%0b exp sec=%0d run=%0b done=%0b",
                     count_sec, running, done, i, (i != 0), (i == 0));
         end
      end
      step(0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (done !== 1'b0) begin
         errors++; $display("FAIL t1_done_width got done=%0b exp 0", done);
      end
   endtask

   task automatic test_double_borrow();
      step(1, 1, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0, 0, 1);
      checks++;
      if ({count_hrs, count_min, count_sec} !== {6'd0, 6'd59, 6'd59}) begin
         errors++;
         $display("FAIL t2_borrow got %0d:%0d:%0d exp 0:59:59", count_hrs, count_min, count_sec);
      end
   endtask

   task automatic test_stop_priority();
      step(1, 0, 0, 10, 0, 0, 0);
      step(0, 0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 1, 1, 1);
      checks++;
      if ({count_hrs, count_min, count_sec} !== {6'd0, 6'd0, 6'd10} || running !== 1'b0) begin
         errors++;
         $display("FAIL t3_stop got %0d:%0d:%0d run=%0b exp 0:0:10 run=0",
                  count_hrs, count_min, count_sec, running);
      end
      step(0, 0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0, 0, 1);
      checks++;
      if (count_sec !== 6'd9 || running !== 1'b1) begin
         errors++;
         $display("FAIL t3_resume got sec=%0d run=%0b exp sec=9 run=1", count_sec, running);
      end
   endtask

   task automatic test_saturation();
      step(1, 30, 63, 61, 0, 0, 1);
      checks++;
      if ({count_hrs, count_min, count_sec} !== {6'd23, 6'd59, 6'd59}) begin
         errors++;
         $display("FAIL t4_sat got %0d:%0d:%0d exp 23:59:59", count_hrs, count_min, count_sec);
      end
      step(1, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0, 0, 1);
      checks++;
      if ({count_hrs, count_min, count_sec} !== 18'd0 || running !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL t4_zero_start got %0d:%0d:%0d run=%0b done=%0b exp 0:0:0 run=0 done=0",
                  count_hrs, count_min, count_sec, running, done);
      end
   endtask

   task automatic test_expired_hold();
      int seen_done;
      step(1, 0, 0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0, 0, 1);
      checks++;
      if (done !== 1'b1) begin
         errors++; $display("FAIL t5_expire got done=%0b exp 1", done);
      end
      seen_done = 0;
      for (int i = 0; i < 5; i++) begin
         step(0, 0, 0, 0, (i == 2), (i == 4), 1);
         if (done !== 1'b0 || running !== 1'b0 || {count_hrs, count_min, count_sec} !== 18'd0)
            seen_done++;
      end
      step(0, 0, 0, 0, 1, 0, 0);
      checks++;
      if (seen_done != 0 || running !== 1'b0) begin
         errors++;
         $display("FAIL t5_hold got bad_cycles=%0d run=%0b exp bad_cycles=0 run=0", seen_done, running);
      end
      step(1, 0, 0, 2, 0, 0, 0);
      checks++;
      if (count_sec !== 6'd2 || running !== 1'b0) begin
         errors++;
         $display("FAIL t5_reload got sec=%0d run=%0b exp sec=2 run=0", count_sec, running);
      end
      step(0, 0, 0, 0, 1, 0, 0);
      checks++;
      if (running !== 1'b1) begin
         errors++; $display("FAIL t5_restart got run=%0b exp 1", running);
      end
   endtask

   task automatic test_async_reset();
      step(1, 0, 5, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0, 0, 1);
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if ({count_hrs, count_min, count_sec, running, done} !== 20'd0) begin
         errors++;
         $display("FAIL t6_async got %0d:%0d:%0d run=%0b done=%0b exp all 0",
                  count_hrs, count_min, count_sec, running, done);
      end
      @(negedge clk);
      reset = 1'b0;
      tick = 0; start = 0; load = 0; stop = 0;
      m_total = 0; m_mode = 0; m_done = 0;
      step(0, 0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0, 1);
      checks++;
      if ({count_hrs, count_min, count_sec, running, done} !== 20'd0) begin
         errors++;
         $display("FAIL t6_after got %0d:%0d:%0d run=%0b done=%0b exp all 0",
                  count_hrs, count_min, count_sec, running, done);
      end
   endtask

   task automatic test_random();
      int eh, em, es;
      bit ld, st, sp, tk;
      int lh, lm, ls;
      do_reset();
      for (int n = 0; n < 600; n++) begin
         ld = ($urandom_range(0, 19) == 0);
         st = ($urandom_range(0, 5) == 0);
         sp = ($urandom_range(0, 15) == 0);
         tk = ($urandom_range(0, 1) == 0);
         if ($urandom_range(0, 3) == 0) begin
            lh = $urandom_range(0, 63); lm = $urandom_range(0, 63); ls = $urandom_range(0, 63);
         end else begin
            lh = $urandom_range(0, 1); lm = $urandom_range(0, 1); ls = $urandom_range(0, 6);
         end
         step(ld, lh, lm, ls, st, sp, tk);
         eh = m_total / 3600;
         em = (m_total / 60) % 60;
         es = m_total % 60;
         checks++;
         if (count_hrs !== 6'(eh) || count_min !== 6'(em) || count_sec !== 6'(es) ||
             running !== (m_mode == 1) || done !== m_done) begin
            errors++;
            $display("FAIL rand_%0d got %0d:%0d:%0d run=%0b done=%0b exp %0d:%0d:%0d run=%0b done=%0b",
                     n, count_hrs, count_min, count_sec, running, done,
                     eh, em, es, (m_mode == 1), m_done);
         end
      end
   endtask

   initial begin
      test_reset();
      test_expiry();
      test_double_borrow();
      test_stop_priority();
      test_saturation();
      test_expired_hold();
      test_async_reset();
      test_random();
      idle_inputs();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
